latch_bank_ctrl: RTL and testbench

- Write controller and arbiter for a bank of DEPTH level-sensitive D latches. Each latch has active-low clear, enable, D in and Q out.
- Shares the bank between NREQ requesters. Each write is sequenced as setup, then enable pulse, then hold, so D is stable whenever any latch enable is high.
- Sits between bus-side requesters and the latch array. Latch Q outputs go straight to consumers; this block does not read them.

---
 rtl/latch_bank_pkg.sv | 30 +++
 rtl/latch_bank_ctrl_rr_arbiter.sv | 44 ++++
 rtl/latch_bank_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_latch_bank_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// -----------------------------------------------------------------------------
// latch_bank_pkg
//
// Shared definitions for the latch bank write controller:
//   - state_t  : controller FSM encoding (3 bits)
//   - EN_CNT_W : width of the enable-pulse cycle counter
//   - rr_next  : round-robin pointer advance with wrap
//
// Optional feature macro: LATCH_BANK_CTRL_CLR_EN (adds the ST_CLR state use
// in latch_bank_ctrl; the encoding is always present).
// -----------------------------------------------------------------------------
package latch_bank_pkg;

    localparam int EN_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLR   = 3'd5   // only reachable when the bank-clear command is built in
    } state_t;

    // Pointer to the requester after idx, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : latch_bank_pkg

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin pick. Searches req starting at rr_ptr and
// wrapping; the first set bit wins. The caller registers the result.
//
// Ports:
//   req      in  NREQ  request vector
//   rr_ptr   in  IW    index where the search starts (must be < NREQ)
//   gnt_oh   out NREQ  one-hot winner (all zero when no request)
//   gnt_idx  out IW    binary index of the winner (0 when no request)
//   gnt_vld  out 1     at least one request was present
// -----------------------------------------------------------------------------
module rr_arbiter
    import latch_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise an unassigned path would infer a latch.
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_vld && req[j]) begin
                gnt_vld    = 1'b1;
                gnt_oh[j]  = 1'b1;
                gnt_idx    = IW'(j);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_ctrl
//
// Write controller and round-robin arbiter for a bank of DEPTH level-sensitive
// D latches shared by NREQ requesters. Each write runs
//   IDLE -> SETUP -> PULSE (EN_CYC cycles) -> HOLD -> DONE -> IDLE
// so the shared D bus is stable one cycle before and one cycle after any
// latch enable is high. All outputs come straight from flops.
//
// Optional feature macro: LATCH_BANK_CTRL_CLR_EN
//   defined   : adds input clr; a clr seen in IDLE with no request pulses
//               lat_rst_n low for one cycle (busy high during it).
//   undefined : no clr port; lat_rst_n is low only while in reset.
//
// Ports:
//   clk        in  1          system clock, rising edge
//   rst        in  1          synchronous reset, active high
//   clr        in  1          bank clear command (only with the macro)
//   req        in  NREQ       per-requester write request, level, held until done
//   addr       in  NREQ*AW    target word per requester, slice i = addr[i*AW +: AW]
//   wdata      in  NREQ*DW    write data per requester
//   gnt        out NREQ       one-hot grant, SETUP through DONE
//   done       out NREQ       one-cycle completion pulse to the winner
//   lat_d      out DW         shared latch D bus
//   lat_en     out DEPTH      per-word latch enable, at most one bit high
//   lat_rst_n  out 1          shared active-low latch clear
//   busy       out 1          high in every state except IDLE
// -----------------------------------------------------------------------------
module latch_bank_ctrl #(
    parameter int NREQ   = 4,
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int EN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef LATCH_BANK_CTRL_CLR_EN
    input  logic                 clr,
`endif
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        lat_d,
    output logic [DEPTH-1:0]     lat_en,
    output logic                 lat_rst_n,
    output logic                 busy
);

    import latch_bank_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_t                state_q,     state_d;
    logic [EN_CNT_W-1:0]   en_cnt_q,    en_cnt_d;
    logic [NREQ-1:0]       gnt_q,       gnt_d;
    logic [NREQ-1:0]       done_q,      done_d;
    logic [IW-1:0]         win_idx_q,   win_idx_d;
    logic [IW-1:0]         rr_ptr_q,    rr_ptr_d;
    logic [AW-1:0]         addr_q,      addr_d;
    logic [DW-1:0]         lat_d_q,     lat_d_d;     // captured wdata doubles as the D bus
    logic [DEPTH-1:0]      lat_en_q,    lat_en_d;
    logic                  lat_rst_n_q, lat_rst_n_d;
    logic                  busy_q,      busy_d;

    // Arbiter result for the current request vector
    logic [NREQ-1:0]       arb_oh;
    logic [IW-1:0]         arb_idx;
    logic                  arb_vld;

    // Selected requester's inputs (one-hot mux on the arbiter result)
    logic [AW-1:0]         sel_addr;
    logic [DW-1:0]         sel_wdata;

    logic                  pulse_last;
    logic                  clr_go;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Addresses at or above DEPTH decode to no enable at all, so an
    // out-of-range write runs its full sequence without touching the bank.
    function automatic logic [DEPTH-1:0] word_decode(input logic [AW-1:0] a);
        logic [DEPTH-1:0] dec;
        dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dec[i] = (a == AW'(i));
        end
        return dec;
    endfunction

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_oh[i]) begin
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    assign pulse_last = (en_cnt_q == EN_CNT_W'(EN_CYC));

`ifdef LATCH_BANK_CTRL_CLR_EN
    // A pending request always wins over a clear in the same cycle.
    assign clr_go = clr && !arb_vld;
`else
    assign clr_go = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (rst) begin
            state_q  <= ST_IDLE;
            en_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            en_cnt_q <= en_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        en_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_SETUP;
                end else if (clr_go) begin
                    state_d = ST_CLR;
                end
            end
            ST_SETUP: begin
                state_d  = ST_PULSE;
                en_cnt_d = EN_CNT_W'(1);   // counter holds the index of the current pulse cycle
            end
            ST_PULSE: begin
                if (pulse_last) begin
                    state_d = ST_HOLD;
                end else begin
                    en_cnt_d = en_cnt_q + EN_CNT_W'(1);
                end
            end
            ST_HOLD:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_CLR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ---------------------------------------------------------------------
    always_comb begin
        gnt_d       = gnt_q;
        done_d      = '0;
        win_idx_d   = win_idx_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        lat_d_d     = lat_d_q;
        lat_rst_n_d = 1'b1;
        busy_d      = (state_d != ST_IDLE);
        // Enable follows the next state directly, so it is high for exactly
        // the cycles spent in PULSE and low everywhere else.
        lat_en_d    = (state_d == ST_PULSE) ? word_decode(addr_q) : '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gnt_d     = arb_oh;
                    win_idx_d = arb_idx;
                    addr_d    = sel_addr;
                    lat_d_d   = sel_wdata;
                end else if (clr_go) begin
                    lat_rst_n_d = 1'b0;
                end
            end
            ST_HOLD: begin
                done_d = gnt_q;
            end
            ST_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = IW'(rr_next(int'(win_idx_q), NREQ));
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output / datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every register here is reset; there is no storage array in
        // this block, so nothing is left to power up unknown.
        if (rst) begin
            gnt_q       <= '0;
            done_q      <= '0;
            win_idx_q   <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            lat_d_q     <= '0;
            lat_en_q    <= '0;
            lat_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            win_idx_q   <= win_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            lat_d_q     <= lat_d_d;
            lat_en_q    <= lat_en_d;
            lat_rst_n_q <= lat_rst_n_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign lat_d     = lat_d_q;
    assign lat_en    = lat_en_q;
    assign lat_rst_n = lat_rst_n_q;
    assign busy      = busy_q;

endmodule : latch_bank_ctrl

// File: tb/tb_latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_ctrl
//
// Scoreboard bench for latch_bank_ctrl. The stimulus side keeps a
// transaction-level model (pending set, round-robin pointer, the cycle the
// bank becomes free) and pushes one expected write per arbitration into
// exp_q. A monitor samples the DUT 1 time unit after each rising edge and
// pops/compares whenever done is presented.
// Optional macro LATCH_BANK_CTRL_CLR_EN enables the clr port and its tests.
// -----------------------------------------------------------------------------
module tb_latch_bank_ctrl;

    localparam int NREQ   = 4;
    localparam int DW     = 8;
    localparam int DEPTH  = 3;
    localparam int AW     = 2;
    localparam int EN_CYC = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [DW-1:0]       lat_d;
    logic [DEPTH-1:0]    lat_en;
    logic                lat_rst_n;
    logic                busy;

    latch_bank_ctrl #(
        .NREQ   (NREQ),
        .DW     (DW),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .EN_CYC (EN_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef LATCH_BANK_CTRL_CLR_EN
        .clr       (clr),
`endif
        .req       (req),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .lat_d     (lat_d),
        .lat_en    (lat_en),
        .lat_rst_n (lat_rst_n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;   // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Expected write: winner, captured addr/data, and the edge that granted it.
    typedef struct {
        int w;
        int a;
        int d;
        int e;
    } txn_t;
    txn_t exp_q[$];

    // ---------------------------------------------------------------------
    // Transaction-level reference model (stimulus side)
    // ---------------------------------------------------------------------
    bit [NREQ-1:0] pend;
    int            a_m [NREQ];
    int            d_m [NREQ];
    int            rr_m;
    bit            active;
    int            act_w;
    int            done_e;       // cycle count at which done is visible
    int            next_arb_e;   // first edge at which the bank can arbitrate again

    task automatic raise(input int i, input int a, input int d);
        req[i]             = 1'b1;
        addr[i*AW +: AW]   = AW'(a);
        wdata[i*DW +: DW]  = DW'(d);
        pend[i]            = 1'b1;
        a_m[i]             = a;
        d_m[i]             = d;
    endtask

    // Decide the winner for the upcoming edge if the bank is free.
    task automatic arbitrate();
        int w;
        if (!active && (cyc + 1 >= next_arb_e) && pend != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (rr_m + k) % NREQ;
                if (w < 0 && pend[j]) w = j;
            end
            exp_q.push_back('{w: w, a: a_m[w], d: d_m[w], e: cyc + 1});
            active     = 1'b1;
            act_w      = w;
            done_e     = cyc + 1 + EN_CYC + 2;
            next_arb_e = cyc + 1 + EN_CYC + 4;
        end
    endtask

    // One stimulus cycle: release on done, disturb the active requester's
    // inputs, raise new requests with probability p percent, arbitrate.
    task automatic tick(input int p);
        int released;
        released = -1;
        @(negedge clk);
        if (active && cyc == done_e) begin
            req[act_w]  = 1'b0;
            pend[act_w] = 1'b0;
            rr_m        = (act_w + 1) % NREQ;
            active      = 1'b0;
            released    = act_w;
        end
        if (active) begin
            if ($urandom_range(3) == 0) begin
                addr[act_w*AW +: AW]  = AW'($urandom);
                wdata[act_w*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(7) == 0) req[act_w] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && i != released && int'($urandom_range(99)) < p)
                raise(i, int'($urandom_range(3)), int'($urandom_range(255)));
        end
        arbitrate();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((active || pend != '0) && n < 400) begin
            tick(0);
            n++;
        end
        repeat (2) tick(0);
        check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    logic [NREQ-1:0] prev_gnt;
    logic [DW-1:0]   setup_d;
    int              setup_cyc;
    int              first_en;
    int              en_cnt;
    int              en_word;
    int              idle_chk;

    always @(posedge clk) begin
        txn_t t;
        #1;
        if (rst) begin
            prev_gnt  = '0;
            en_cnt    = 0;
            en_word   = -1;
            first_en  = -1;
            setup_cyc = -1;
            idle_chk  = -1;
        end else begin
            check("lat_en_onehot0", 64'($onehot0(lat_en)), 64'd1);
            check("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            if (gnt != '0 && prev_gnt == '0) begin
                setup_cyc = cyc;
                setup_d   = lat_d;
                check("setup_lat_en_low", 64'(lat_en), 64'd0);
            end
            if (lat_en != '0) begin
                if (en_cnt == 0) first_en = cyc;
                en_cnt++;
                for (int i = 0; i < DEPTH; i++) if (lat_en[i]) en_word = i;
                check("lat_d_stable_in_pulse", 64'(lat_d), 64'(setup_d));
            end
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    t = exp_q.pop_front();
                    check("done_onehot", 64'(done), 64'(1) << t.w);
                    check("gnt_at_done", 64'(gnt), 64'(1) << t.w);
                    check("done_cycle", 64'(cyc), 64'(t.e + EN_CYC + 2));
                    check("setup_cycle", 64'(setup_cyc), 64'(t.e));
                    check("setup_lat_d", 64'(setup_d), 64'(t.d));
                    check("lat_d_at_done", 64'(lat_d), 64'(t.d));
                    check("busy_at_done", 64'(busy), 64'd1);
                    check("pulse_len", 64'(en_cnt), 64'((t.a < DEPTH) ? EN_CYC : 0));
                    if (t.a < DEPTH) begin
                        check("pulse_word", 64'(en_word), 64'(t.a));
                        check("pulse_start", 64'(first_en), 64'(t.e + 1));
                    end
                end
                en_cnt   = 0;
                en_word  = -1;
                idle_chk = cyc + 1;
            end
            if (cyc == idle_chk) begin
                check("idle_gnt", 64'(gnt), 64'd0);
                check("idle_done", 64'(done), 64'd0);
                check("idle_busy", 64'(busy), 64'd0);
                check("idle_lat_en", 64'(lat_en), 64'd0);
            end
            prev_gnt = gnt;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int e_abort;
        rst   = 1'b1;
        clr   = 1'b0;
        req   = '0;
        addr  = '0;
        wdata = '0;
        pend  = '0;
        rr_m  = 0;
        active     = 1'b0;
        next_arb_e = 0;

        // Reset held for two edges
        repeat (2) @(negedge clk);
        check("rst_lat_rst_n", 64'(lat_rst_n), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lat_en", 64'(lat_en), 64'd0);
        check("rst_lat_d", 64'(lat_d), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_lat_rst_n", 64'(lat_rst_n), 64'd1);
        check("rel_busy", 64'(busy), 64'd0);

        // Single directed write: requester 0, word 2, data A5
        tick(0);
        raise(0, 2, 8'hA5);
        arbitrate();
        drain();

        // Full contention: all requesters raised together, re-raised after each done
        tick(0);
        for (int i = 0; i < NREQ; i++)
            raise(i, int'($urandom_range(3)), int'($urandom_range(255)));
        arbitrate();
        repeat (60) tick(100);
        drain();

        // Random traffic including out-of-range word 3
        repeat (600) tick(25);
        drain();

        // Leave the round-robin pointer at 3 before the aborted write
        tick(0);
        raise(2, 0, 8'h11);
        arbitrate();
        drain();

        // Reset during the 2nd pulse cycle; no done may follow
        @(negedge clk);
        raise(1, 1, 8'h3C);
        e_abort = cyc + 1;
        while (cyc < e_abort + 2) @(negedge clk);
        check("abort_pulse_on", 64'(lat_en), 64'b010);
        rst = 1'b1;
        @(negedge clk);
        check("abort_lat_en", 64'(lat_en), 64'd0);
        check("abort_lat_rst_n", 64'(lat_rst_n), 64'd0);
        check("abort_gnt", 64'(gnt), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_lat_d", 64'(lat_d), 64'd0);
        req  = '0;
        pend = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rel_lat_rst_n", 64'(lat_rst_n), 64'd1);
        check("abort_rel_busy", 64'(busy), 64'd0);
        repeat (EN_CYC + 6) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        rr_m       = 0;
        active     = 1'b0;
        next_arb_e = 0;

        // Pointer must be back at 0: requester 1 beats requester 3
        tick(0);
        raise(3, 2, 8'hC3);
        raise(1, 0, 8'h96);
        arbitrate();
        drain();

`ifdef LATCH_BANK_CTRL_CLR_EN
        // Clear alone: one-cycle lat_rst_n pulse
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_lat_rst_n_low", 64'(lat_rst_n), 64'd0);
        check("clr_busy", 64'(busy), 64'd1);
        check("clr_gnt", 64'(gnt), 64'd0);
        @(negedge clk);
        check("clr_lat_rst_n_back", 64'(lat_rst_n), 64'd1);
        check("clr_busy_back", 64'(busy), 64'd0);

        // Clear together with a request: the write wins, the clear is dropped
        tick(0);
        clr = 1'b1;
        raise(2, 1, 8'h5A);
        arbitrate();
        tick(0);
        clr = 1'b0;
        check("clr_req_lat_rst_n", 64'(lat_rst_n), 64'd1);
        check("clr_req_gnt", 64'(gnt), 64'b0100);
        repeat (3) begin
            tick(0);
            check("clr_req_lat_rst_n_hold", 64'(lat_rst_n), 64'd1);
        end
        drain();
`endif

        check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the run is a few thousand cycles; this bound is far beyond it.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_latch_bank_ctrl
